// File: rtl/bound_flash_seq.sv
// bound_flash_seq: bound-flasher sequencer with step prescaler, flick synchronizer and 16-lamp thermometer.
// Define BOUND_FLASH_LATCH_EN to remember flick pulses that fall between ticks.
module bound_flash_seq #(
    parameter int TICK_DIV = 50_000_000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flick,
    output logic [15:0] led,
    output logic [4:0]  level,
    output logic [2:0]  state,
    output logic        busy,
    output logic        tick
);
    localparam int CW = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
    typedef enum logic [2:0] {IDLE, UP6, DN0, UP11, DN5, UP16, DNEND} state_t;
    state_t        st, ns;
    logic [CW-1:0] cnt;
    logic [1:0]    sync;
    logic          flick_s, fl, up, dn, kick;
    logic [4:0]    nl;
    logic [15:0]   therm;
    assign tick    = cnt == CW'(TICK_DIV - 1);
    assign flick_s = sync[1];
    assign state   = st;
    assign busy    = st != IDLE;
`ifdef BOUND_FLASH_LATCH_EN
    logic flick_req;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) flick_req <= 1'b0;
        else        flick_req <= !tick && (flick_req || flick_s);
    assign fl = flick_s | flick_req;
`else
    assign fl = flick_s;
`endif
    // decisions are made on the level this tick will produce
    always_comb begin
        up    = st inside {UP6, UP11, UP16};
        dn    = st inside {DN0, DN5, DNEND};
        nl    = up ? (level == 5'd16 ? level : level + 5'd1) :
                dn ? (level == 5'd0 ? level : level - 5'd1) : {4'd0, st == IDLE && fl};
        kick  = fl && (nl == 5'd6 || nl == 5'd11);
        therm = ~(16'hFFFF << nl);
        ns    = IDLE;
        case (st)
            IDLE:    ns = fl ? UP6 : IDLE;
            UP6:     ns = nl == 5'd6 ? DN0 : UP6;
            DN0:     ns = nl == 5'd0 ? UP11 : DN0;
            UP11:    ns = kick ? DN0 : nl == 5'd11 ? DN5 : UP11;
            DN5:     ns = nl == 5'd5 ? UP16 : DN5;
            UP16:    ns = kick ? DN5 : nl == 5'd16 ? DNEND : UP16;
            DNEND:   ns = nl == 5'd0 ? IDLE : DNEND;
            default: ns = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            cnt   <= '0;
            sync  <= 2'b00;
            st    <= IDLE;
            level <= 5'd0;
            led   <= 16'h0000;
        end else begin
            cnt  <= tick ? '0 : cnt + 1'b1;
            sync <= {sync[0], flick};
            if (tick) begin
                st    <= ns;
                level <= nl;
                led   <= therm;
            end
        end
endmodule

// File: tb/tb_bound_flash_seq.sv
// tb_bound_flash_seq: directed checks of the bound-flasher sequence with TICK_DIV=4.
module tb_bound_flash_seq;
    logic        clk = 1'b0, rst_n = 1'b0, flick = 1'b0;
    logic [15:0] led;
    logic [4:0]  level;
    logic [2:0]  state;
    logic        busy, tick;
    int          vecs = 0, miss = 0, ticks = 0, cyc = 0, lvl_m = 0, t0 = 0, n0 = 0;

    bound_flash_seq #(.TICK_DIV(4)) dut (
        .clk(clk), .rst_n(rst_n), .flick(flick), .led(led),
        .level(level), .state(state), .busy(busy), .tick(tick)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input int got, input int exp);
        vecs++;
        if (got !== exp) begin
            miss++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    function automatic int therm(input int l);
        return (1 << l) - 1;
    endfunction

    // advance to the negedge just after the next tick edge
    task automatic step_tick();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (tick !== 1'b1 && n < 8);
        check("tick_seen", int'(tick), 1);
        @(negedge clk);
        ticks++;
    endtask

    task automatic expect_now(input string tag, input int st);
        check($sformatf("%s_level", tag), int'(level), lvl_m);
        check($sformatf("%s_state", tag), int'(state), st);
        check($sformatf("%s_led", tag), int'(led), therm(lvl_m));
    endtask

    task automatic seg(input int tgt, input int cur, input int nxt, input string tag);
        while (lvl_m != tgt) begin
            lvl_m += (tgt > lvl_m) ? 1 : -1;
            step_tick();
            expect_now(tag, lvl_m == tgt ? nxt : cur);
        end
    endtask

    task automatic start_run();
        step_tick();
        flick = 1'b1;
        step_tick();
        flick = 1'b0;
        lvl_m = 1;
        expect_now("start", 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        check("rst_led", int'(led), 0);
        check("rst_state", int'(state), 0);
        check("rst_level", int'(level), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_tick", int'(tick), 0);
        rst_n = 1'b1;
        for (int k = 1; k <= 100; k++) begin
            @(negedge clk);
            check("idle_tick", int'(tick), int'(k % 4 == 3));
        end
        check("idle_led", int'(led), 0);
        check("idle_state", int'(state), 0);
        check("idle_busy", int'(busy), 0);

        // full run without kickback
        t0 = cyc;
        n0 = ticks;
        flick = 1'b1;
        step_tick();
        flick = 1'b0;
        lvl_m = 1;
        expect_now("run_start", 1);
        check("run_busy", int'(busy), 1);
        seg(6, 1, 2, "run_up6");
        seg(0, 2, 3, "run_dn0");
        seg(11, 3, 4, "run_up11");
        seg(5, 4, 5, "run_dn5");
        seg(16, 5, 6, "run_up16");
        seg(0, 6, 0, "run_dnend");
        check("run_ticks", ticks - n0, 56);
        check("run_clocks", cyc - t0, 224);
        check("run_end_busy", int'(busy), 0);
        step_tick();
        expect_now("run_idle_hold", 0);

        // kickback in UP11, then kickback in UP16
        start_run();
        seg(6, 1, 2, "k_up6");
        seg(0, 2, 3, "k_dn0");
        flick = 1'b1;
        seg(6, 3, 2, "k_up11_kick");
        flick = 1'b0;
        seg(0, 2, 3, "k_dn0_again");
        seg(11, 3, 4, "k_up11");
        seg(5, 4, 5, "k_dn5");
        seg(10, 5, 5, "k_up16");
        flick = 1'b1;
        seg(11, 5, 4, "k_up16_kick");
        flick = 1'b0;
        seg(5, 4, 5, "k_dn5_again");
        seg(16, 5, 6, "k_up16_done");
        seg(0, 6, 0, "k_dnend");

        // asynchronous reset at level 9 in UP11
        start_run();
        seg(6, 1, 2, "r_up6");
        seg(0, 2, 3, "r_dn0");
        seg(9, 3, 3, "r_up11");
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_led", int'(led), 0);
        check("mid_rst_state", int'(state), 0);
        check("mid_rst_level", int'(level), 0);
        check("mid_rst_busy", int'(busy), 0);
        @(negedge clk);
        rst_n = 1'b1;
        lvl_m = 0;
        repeat (3) begin
            step_tick();
            expect_now("post_rst_idle", 0);
        end

        // 3-clock pulse whose synchronized copy misses both tick edges
        repeat (2) @(negedge clk);
        flick = 1'b1;
        repeat (3) @(negedge clk);
        flick = 1'b0;
        check("pulse_pre_state", int'(state), 0);
        step_tick();
`ifdef BOUND_FLASH_LATCH_EN
        lvl_m = 1;
        expect_now("pulse_latched", 1);
`else
        lvl_m = 0;
        expect_now("pulse_lost", 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
        $finish;
    end
endmodule
